// File: rtl/din_gen.sv
// din_gen: programmable burst stimulus source driving a din_valid/din_data stream.
// Define DIN_GEN_LFSR_EN to build the LFSR datapath selected by cfg_mode.
module din_gen #(
    parameter int                DWIDTH = 16,
    parameter int                LWIDTH = 16,
    parameter int                GWIDTH = 8,
    parameter logic [DWIDTH-1:0] TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LWIDTH-1:0] cfg_len,
    input  logic [GWIDTH-1:0] cfg_gap,
    input  logic [DWIDTH-1:0] cfg_seed,
    input  logic              cfg_mode,
    output logic              busy,
    output logic              done,
    output logic [LWIDTH-1:0] beat_cnt,
    output logic              din_valid,
    output logic [DWIDTH-1:0] din_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LWIDTH-1:0] len_r;
    logic [GWIDTH-1:0] gap_r;
    logic [GWIDTH-1:0] gap_cnt;
    logic [DWIDTH-1:0] cur;
    logic [DWIDTH-1:0] next_data;
    logic [DWIDTH-1:0] seed_load;
    logic              last_beat;

    // beat_cnt still holds the pre-increment count while the beat is on the bus
    assign last_beat = (beat_cnt == len_r - LWIDTH'(1));

`ifdef DIN_GEN_LFSR_EN
    logic mode_r;

    function automatic logic [DWIDTH-1:0] lfsr_next(input logic [DWIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed starts at 1
    assign seed_load = (cfg_mode && cfg_seed == '0) ? DWIDTH'(1) : cfg_seed;
    assign next_data = mode_r ? lfsr_next(cur) : cur + DWIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst)
            mode_r <= 1'b0;
        else if (state == IDLE && start)
            mode_r <= cfg_mode;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{cfg_mode, TAPS};
    assign seed_load  = cfg_seed;
    assign next_data  = cur + DWIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (cfg_len == '0) ? DONE : SEND;
            SEND: begin
                if (last_beat)
                    state_nxt = DONE;
                else if (gap_r != '0)
                    state_nxt = GAP;
                else
                    state_nxt = SEND;
            end
            GAP:  if (gap_cnt == GWIDTH'(1)) state_nxt = SEND;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SEND) || (state == GAP);
        done      = (state == DONE);
        din_valid = (state == SEND);
        din_data  = (state == SEND) ? cur : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_r    <= '0;
            gap_r    <= '0;
            gap_cnt  <= '0;
            cur      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r    <= cfg_len;
                        gap_r    <= cfg_gap;
                        cur      <= seed_load;
                        beat_cnt <= '0;
                    end
                end
                SEND: begin
                    beat_cnt <= beat_cnt + LWIDTH'(1);
                    cur      <= next_data;
                    gap_cnt  <= gap_r;
                end
                GAP:     gap_cnt <= gap_cnt - GWIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_din_gen.sv
// Self-checking bench for din_gen: directed and randomized bursts against a
// cycle-offset reference model of the burst timing and data sequence.
module tb_din_gen;

    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [7:0]  cfg_gap = '0;
    logic [15:0] cfg_seed = '0;
    logic        cfg_mode = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic        din_valid;
    logic [15:0] din_data;

    int vectors = 0;
    int miscompares = 0;

    din_gen #(.DWIDTH(16), .LWIDTH(16), .GWIDTH(8), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_mode(cfg_mode),
        .busy(busy), .done(done), .beat_cnt(beat_cnt),
        .din_valid(din_valid), .din_data(din_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, din_valid, beat_cnt, din_data} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b done=%0b valid=%0b beat_cnt=%0h data=%0h, want all 0",
                     busy, done, din_valid, beat_cnt, din_data);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (din_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_quiet cycle %0d: got valid=%0b done=%0b busy=%0b, want 0 0 0",
                         c, din_valid, done, busy);
            end
        end
    endtask

    // Beat k lands at offset 1 + k*(gap+1) after the accepting edge; done follows the last beat.
    task automatic test_burst(input int len, input int gap, input logic [15:0] seed,
                              input bit mode, input string name);
        logic [15:0] exp_q[$];
        logic [15:0] x;
        logic [18:0] obs, exp_v;
        bit          lfsr, ev, eb, ed;
        int          period, last_c, total;
        lfsr = 1'b0;
`ifdef DIN_GEN_LFSR_EN
        lfsr = mode;
`endif
        x = (lfsr && seed == 16'h0) ? 16'h0001 : seed;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(x);
            x = lfsr ? ((x >> 1) ^ (x[0] ? TAPS : 16'h0)) : x + 16'h1;
        end
        period = gap + 1;
        last_c = (len == 0) ? 0 : 1 + (len - 1) * period;
        total  = last_c + 1;

        @(negedge clk);
        cfg_len  = 16'(len);
        cfg_gap  = 8'(gap);
        cfg_seed = seed;
        cfg_mode = mode;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cfg_len  = 16'($urandom);
        cfg_gap  = 8'($urandom);
        cfg_seed = 16'($urandom);
        cfg_mode = 1'($urandom);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            eb = (c <= last_c);
            ev = eb && ((c - 1) % period == 0);
            ed = (c == total);
            exp_v = {ev, eb, ed, ev ? exp_q[(c - 1) / period] : 16'h0};
            obs   = {din_valid, busy, done, din_data};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle T+%0d: got valid=%0b busy=%0b done=%0b data=%h, want valid=%0b busy=%0b done=%0b data=%h",
                         name, c, obs[18], obs[17], obs[16], obs[15:0],
                         exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
            if (ed) begin
                vectors++;
                if (beat_cnt !== 16'(len)) begin
                    miscompares++;
                    $display("FAIL %s beat_cnt: got %0d, want %0d", name, beat_cnt, len);
                end
            end
        end
    endtask

    task automatic test_start_held();
        logic [15:0] seed;
        bit          ev, ed;
        logic [15:0] ev_data;
        seed = 16'($urandom);
        @(negedge clk);
        cfg_len  = 16'd2;
        cfg_gap  = 8'd0;
        cfg_seed = seed;
        cfg_mode = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ev = (c == 1 || c == 2 || c == 5 || c == 6);
            ed = (c == 3 || c == 7);
            ev_data = (c == 1 || c == 5) ? seed : (ev ? seed + 16'h1 : 16'h0);
            vectors++;
            if (din_valid !== ev || done !== ed || busy !== ev || din_data !== ev_data) begin
                miscompares++;
                $display("FAIL start_held cycle T+%0d: got valid=%0b done=%0b busy=%0b data=%h, want valid=%0b done=%0b busy=%0b data=%h",
                         c, din_valid, done, busy, din_data, ev, ed, ev, ev_data);
            end
            if (c == 7) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        cfg_len  = 16'd10;
        cfg_gap  = 8'd0;
        cfg_seed = 16'($urandom);
        cfg_mode = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (din_valid !== 1'b1 || beat_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL mid_burst_beat4: got valid=%0b beat_cnt=%0d, want 1 3", din_valid, beat_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, din_valid, beat_cnt, din_data} !== 35'd0) begin
            miscompares++;
            $display("FAIL mid_burst_reset: got busy=%0b done=%0b valid=%0b beat_cnt=%0d data=%h, want all 0",
                     busy, done, din_valid, beat_cnt, din_data);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || din_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_burst_abandon cycle %0d: got done=%0b valid=%0b busy=%0b, want 0 0 0",
                         c, done, din_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_burst((i == 5) ? 0 : int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                       16'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_burst(4, 0, 16'hFFFE, 1'b0, "counter_wrap");
        test_burst(3, 2, 16'h0010, 1'b0, "gapped");
`ifdef DIN_GEN_LFSR_EN
        test_burst(3, 0, 16'h0001, 1'b1, "lfsr");
        test_burst(3, 0, 16'h0000, 1'b1, "lfsr_seed0");
`else
        test_burst(3, 0, 16'h0000, 1'b1, "mode_ignored");
`endif
        test_burst(0, 1, 16'h1234, 1'b0, "zero_len");
        test_start_held();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
